// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// spi_pkg : shared SPI register addresses, field layouts, FSM codes, resets
// Rev 1.0
// ============================================================================
package spi_pkg;

  localparam int unsigned ADDR_CR1 = 0;
  localparam int unsigned ADDR_CR2 = 1;
  localparam int unsigned ADDR_BR  = 2;
  localparam int unsigned ADDR_SR  = 3;
  localparam int unsigned ADDR_DR  = 5;

  // CR1 layout, MSB first; spi_core decodes the same structure
  typedef struct packed {
    logic spe;
    logic mstr;
    logic cpol;
    logic cpha;
    logic ssoe;
    logic lsbfe;
    logic modfen;
    logic spiswai;
  } cr1_t;

  localparam int unsigned CR2_SPIE    = 7;
  localparam int unsigned CR2_SPTIE   = 6;
  localparam int unsigned CR2_ERRIE   = 5;
  localparam int unsigned CR2_BIDIROE = 1;
  localparam int unsigned CR2_SPC0    = 0;

  localparam int unsigned BR_SPPR_LSB = 4;
  localparam int unsigned BR_SPR_LSB  = 0;

  localparam int unsigned SR_SPIF  = 7;
  localparam int unsigned SR_OVRF  = 6;
  localparam int unsigned SR_SPTEF = 5;
  localparam int unsigned SR_MODF  = 4;

  localparam logic [7:0] CR2_RST = 8'h00;
  localparam logic [7:0] BR_RST  = 8'h00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/spi_regs.sv
`default_nettype none
// ============================================================================
// spi_regs : SPI register file, TX/RX buffering and one-byte transfer sequencer
// Rev 1.0
// ============================================================================
module spi_regs
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter logic [7:0]  CR1_RST = 8'h04
) (
  input  logic              clk_in,
  input  logic              rstn_in,
  input  logic              sel_in,
  input  logic              wr_in,
  input  logic              rd_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [7:0]        wdata_in,
  output logic [7:0]        rdata_out,
  output logic [7:0]        spi_cr1_out,
  output logic              spie_out,
  output logic              sptie_out,
  output logic              errie_out,
  output logic              bidiroe_out,
  output logic              spc0_out,
  output logic [2:0]        sppr_out,
  output logic [2:0]        spr_out,
  output logic [7:0]        spi_dr_out,
  output logic              new_tx_out,
  input  logic              finished_in,
  input  logic [7:0]        shift_in,
  input  logic              mode_fault_in,
  output logic              irq_out
);

  localparam logic [ADDR_W-1:0] A_CR1 = ADDR_W'(ADDR_CR1);
  localparam logic [ADDR_W-1:0] A_CR2 = ADDR_W'(ADDR_CR2);
  localparam logic [ADDR_W-1:0] A_BR  = ADDR_W'(ADDR_BR);
  localparam logic [ADDR_W-1:0] A_SR  = ADDR_W'(ADDR_SR);
  localparam logic [ADDR_W-1:0] A_DR  = ADDR_W'(ADDR_DR);

  cr1_t       cr1_q, cr1_d, wcr1;
  logic [7:0] cr2_q, cr2_d, br_q, br_d;
  logic [7:0] tx_buf_q, tx_buf_d, rx_buf_q, rx_buf_d;
  logic [7:0] dr_q, dr_d, rdata_q, rdata_d, sr_val;
  logic       spif_q, spif_d, ovrf_q, ovrf_d, sptef_q, sptef_d, modf_q, modf_d;
  logic       pending_q, pending_d, new_tx_q, new_tx_d, irq_q, irq_d, fin_q, fin_d;
  logic       arm_spif_q, arm_spif_d, arm_modf_q, arm_modf_d;
  logic [1:0] state_q, state_d;
  logic       wr, rd, busy, rise, fault, abort;

  assign wr    = sel_in & wr_in;
  assign rd    = sel_in & rd_in;
  assign busy  = (state_q != ST_IDLE);
  assign rise  = finished_in & ~fin_q & busy;
  assign fault = mode_fault_in & cr1_q.mstr;
  assign wcr1  = cr1_t'(wdata_in);
  // Dropping SPE, by write or by mode fault, cancels any queued or running byte
  assign abort = fault | (wr & (addr_in == A_CR1) & ~wcr1.spe);

  always_comb begin
    sr_val           = 8'h00;
    sr_val[SR_SPIF]  = spif_q;
    sr_val[SR_OVRF]  = ovrf_q;
    sr_val[SR_SPTEF] = sptef_q;
    sr_val[SR_MODF]  = modf_q;
  end

  always_comb begin
    cr1_d      = cr1_q;
    cr2_d      = cr2_q;
    br_d       = br_q;
    tx_buf_d   = tx_buf_q;
    rx_buf_d   = rx_buf_q;
    dr_d       = dr_q;
    rdata_d    = rdata_q;
    spif_d     = spif_q;
    ovrf_d     = ovrf_q;
    sptef_d    = sptef_q;
    modf_d     = modf_q;
    pending_d  = pending_q;
    new_tx_d   = 1'b0;
    fin_d      = finished_in;
    arm_spif_d = arm_spif_q;
    arm_modf_d = arm_modf_q;
    state_d    = state_q;
    irq_d      = (cr2_q[CR2_SPIE] & spif_q) | (cr2_q[CR2_SPTIE] & sptef_q) |
                 (cr2_q[CR2_ERRIE] & (modf_q | ovrf_q));

    if (rd) begin
      case (addr_in)
        A_CR1:   rdata_d = cr1_q;
        A_CR2:   rdata_d = cr2_q;
        A_BR:    rdata_d = br_q;
        A_SR:    rdata_d = sr_val;
        A_DR:    rdata_d = rx_buf_q;
        default: rdata_d = 8'h00;
      endcase
    end

    if (wr) begin
      case (addr_in)
        A_CR1: begin
          cr1_d = wcr1;
          if (arm_modf_q) modf_d = 1'b0;
        end
        A_CR2:   cr2_d = wdata_in;
        A_BR:    br_d  = wdata_in;
        A_DR: begin
          if (sptef_q) begin
            tx_buf_d  = wdata_in;
            pending_d = 1'b1;
            sptef_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (rd && (addr_in == A_DR) && arm_spif_q) begin
      spif_d = 1'b0;
      ovrf_d = 1'b0;
    end

    // An SR read arms each clear sequence; any other access disarms it
    if (rd && (addr_in == A_SR)) begin
      arm_spif_d = spif_q;
      arm_modf_d = modf_q;
    end else if (rd || wr) begin
      arm_spif_d = 1'b0;
      arm_modf_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_q && cr1_q.spe) begin
          new_tx_d  = 1'b1;
          dr_d      = tx_buf_q;
          pending_d = 1'b0;
          sptef_d   = 1'b1;
          state_d   = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_BUSY;
      ST_BUSY:   state_d = ST_BUSY;
      default:   state_d = ST_IDLE;
    endcase

    if (rise) begin
      state_d = ST_IDLE;
      spif_d  = 1'b1;
      if (spif_q) ovrf_d   = 1'b1;
      else        rx_buf_d = shift_in;
    end

    if (fault) begin
      modf_d     = 1'b1;
      cr1_d.mstr = 1'b0;
      cr1_d.spe  = 1'b0;
    end

    if (abort) begin
      pending_d = 1'b0;
      sptef_d   = 1'b1;
      new_tx_d  = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      cr1_q      <= cr1_t'(CR1_RST);
      cr2_q      <= CR2_RST;
      br_q       <= BR_RST;
      tx_buf_q   <= 8'h00;
      rx_buf_q   <= 8'h00;
      dr_q       <= 8'h00;
      rdata_q    <= 8'h00;
      spif_q     <= 1'b0;
      ovrf_q     <= 1'b0;
      sptef_q    <= 1'b1;
      modf_q     <= 1'b0;
      pending_q  <= 1'b0;
      new_tx_q   <= 1'b0;
      irq_q      <= 1'b0;
      fin_q      <= 1'b1;
      arm_spif_q <= 1'b0;
      arm_modf_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      cr1_q      <= cr1_d;
      cr2_q      <= cr2_d;
      br_q       <= br_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      dr_q       <= dr_d;
      rdata_q    <= rdata_d;
      spif_q     <= spif_d;
      ovrf_q     <= ovrf_d;
      sptef_q    <= sptef_d;
      modf_q     <= modf_d;
      pending_q  <= pending_d;
      new_tx_q   <= new_tx_d;
      irq_q      <= irq_d;
      fin_q      <= fin_d;
      arm_spif_q <= arm_spif_d;
      arm_modf_q <= arm_modf_d;
      state_q    <= state_d;
    end
  end

  assign rdata_out   = rdata_q;
  assign spi_cr1_out = cr1_q;
  assign spie_out    = cr2_q[CR2_SPIE];
  assign sptie_out   = cr2_q[CR2_SPTIE];
  assign errie_out   = cr2_q[CR2_ERRIE];
  assign bidiroe_out = cr2_q[CR2_BIDIROE];
  assign spc0_out    = cr2_q[CR2_SPC0];
  assign sppr_out    = br_q[BR_SPPR_LSB +: 3];
  assign spr_out     = br_q[BR_SPR_LSB +: 3];
  assign spi_dr_out  = dr_q;
  assign new_tx_out  = new_tx_q;
  assign irq_out     = irq_q;

endmodule
`default_nettype wire
